// File: rtl/alu_seq.sv
// Sequential ALU with a valid/ready handshake on both sides. Single-cycle ops
// register their result directly; MUL runs a WIDTH-cycle shift-add loop.
module alu_seq #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [3:0]       op,
  input  logic             in_c,
  input  logic [WIDTH-1:0] in_x,
  input  logic [WIDTH-1:0] in_y,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_s,
  output logic             out_c,
  output logic             zero,
  output logic             overflow
);

  localparam int CW = $clog2(WIDTH);
  localparam logic [WIDTH:0] WLIM = (WIDTH+1)'(WIDTH);
  localparam logic [3:0] OP_MUL = 4'd12;

  typedef enum logic [1:0] {IDLE, BUSY, HOLD} state_t;

  typedef struct packed {
    logic [WIDTH-1:0] s;
    logic             c;
    logic             ov;
  } res_t;

  state_t state, state_nx;
  res_t res;

  logic [2*WIDTH-1:0] acc, mcand, acc_sum;
  logic [WIDTH-1:0]   mplier;
  logic [CW-1:0]      cnt;
  logic               accept, last_step;

  assign in_ready  = (state == IDLE) | ((state == HOLD) & out_ready);
  assign out_valid = (state == HOLD);
  assign accept    = in_valid & in_ready;
  assign last_step = (state == BUSY) && (cnt == CW'(WIDTH-1));
  assign acc_sum   = acc + (mplier[0] ? mcand : '0);

  // Single-cycle datapath; MUL result comes from the accumulator instead.
  always_comb begin
    logic [WIDTH:0] sum;
    logic           shift_big;
    res       = '0;
    sum       = '0;
    shift_big = ({1'b0, in_y} >= WLIM);
    case (op)
      4'd0: begin
        sum    = {1'b0, in_x} + {1'b0, in_y} + {{WIDTH{1'b0}}, in_c};
        res.s  = sum[WIDTH-1:0];
        res.c  = sum[WIDTH];
        res.ov = (in_x[WIDTH-1] == in_y[WIDTH-1]) && (sum[WIDTH-1] != in_x[WIDTH-1]);
      end
      4'd1: begin
        sum    = {1'b0, in_x} + {1'b0, ~in_y} + (WIDTH+1)'(1);
        res.s  = sum[WIDTH-1:0];
        res.c  = sum[WIDTH];
        res.ov = (in_x[WIDTH-1] != in_y[WIDTH-1]) && (sum[WIDTH-1] != in_x[WIDTH-1]);
      end
      4'd2:  res.s = ~in_x;
      4'd3:  res.s = in_x & in_y;
      4'd4:  res.s = in_x | in_y;
      4'd5:  res.s = in_x ^ in_y;
      4'd6:  res.s = WIDTH'($signed(in_x) < $signed(in_y));
      4'd7:  res.s = WIDTH'(in_x == in_y);
      4'd8:  res.s = WIDTH'(in_x < in_y);
      4'd9:  res.s = shift_big ? '0 : (in_x << in_y);
      4'd10: res.s = shift_big ? '0 : (in_x >> in_y);
      4'd11: res.s = shift_big ? {WIDTH{in_x[WIDTH-1]}} : WIDTH'($signed(in_x) >>> in_y);
      default: res = '0;
    endcase
  end

  always_comb begin
    state_nx = state;
    case (state)
      IDLE, HOLD: begin
        if (accept)
          state_nx = (op == OP_MUL) ? BUSY : HOLD;
        else if ((state == HOLD) && out_ready)
          state_nx = IDLE;
      end
      BUSY:    if (last_step) state_nx = HOLD;
      default: state_nx = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= IDLE;
      out_s    <= '0;
      out_c    <= 1'b0;
      zero     <= 1'b0;
      overflow <= 1'b0;
      acc      <= '0;
      mcand    <= '0;
      mplier   <= '0;
      cnt      <= '0;
    end else begin
      state <= state_nx;
      if (accept) begin
        if (op == OP_MUL) begin
          acc    <= '0;
          mcand  <= {{WIDTH{1'b0}}, in_x};
          mplier <= in_y;
          cnt    <= '0;
        end else begin
          out_s    <= res.s;
          out_c    <= res.c;
          overflow <= res.ov;
          zero     <= (res.s == '0);
        end
      end else if (state == BUSY) begin
        // One multiplier bit per cycle; the final partial sum goes straight out.
        acc    <= acc_sum;
        mcand  <= mcand << 1;
        mplier <= mplier >> 1;
        cnt    <= cnt + CW'(1);
        if (last_step) begin
          out_s    <= acc_sum[WIDTH-1:0];
          out_c    <= |acc_sum[2*WIDTH-1:WIDTH];
          overflow <= 1'b0;
          zero     <= (acc_sum[WIDTH-1:0] == '0);
        end
      end
    end
  end

endmodule

// File: tb/tb_alu_seq.sv
// Bench for alu_seq: directed literal cases plus randomized traffic checked
// every cycle against a latency/result model built from plain arithmetic.
module tb_alu_seq;
  localparam int W = 8;

  logic         clk = 1'b0;
  logic         rst, in_valid, in_c, out_ready;
  logic [3:0]   op;
  logic [W-1:0] in_x, in_y;
  logic         in_ready, out_valid, out_c, zero, overflow;
  logic [W-1:0] out_s;

  int checks = 0;
  int errors = 0;
  bit chk_en = 0;

  // model state
  bit              m_busy = 0, m_hold = 0, m_acc = 0;
  int              m_left = 0;
  longint unsigned m_s = 0, p_s = 0;
  bit              m_c = 0, m_z = 0, m_ov = 0, p_c = 0, p_z = 0;

  alu_seq #(.WIDTH(W)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready), .op(op),
    .in_c(in_c), .in_x(in_x), .in_y(in_y), .out_valid(out_valid),
    .out_ready(out_ready), .out_s(out_s), .out_c(out_c), .zero(zero),
    .overflow(overflow)
  );

  always #5 clk = ~clk;

  task automatic chk(input string nm, input longint unsigned got, input longint unsigned exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, got, exp, $time);
    end
  endtask

  function automatic longint sval(input longint unsigned v);
    return (v >= (64'd1 << (W-1))) ? longint'(v) - longint'(64'd1 << W) : longint'(v);
  endfunction

  function automatic void ref_op(input int o, input longint unsigned x, input longint unsigned y,
                                 input bit ci, output longint unsigned s, output bit co, output bit ov);
    longint unsigned msk, u;
    longint sx, sy, t;
    msk = (64'd1 << W) - 1;
    sx = sval(x); sy = sval(y);
    s = 0; co = 0; ov = 0;
    case (o)
      0: begin u = x + y + ci; s = u & msk; co = u[W]; t = sx + sy + ci;
               ov = (t > (2**(W-1))-1) || (t < -(2**(W-1))); end
      1: begin u = x + ((~y) & msk) + 1; s = u & msk; co = u[W]; t = sx - sy;
               ov = (t > (2**(W-1))-1) || (t < -(2**(W-1))); end
      2:  s = (~x) & msk;
      3:  s = x & y;
      4:  s = x | y;
      5:  s = x ^ y;
      6:  s = (sx < sy) ? 1 : 0;
      7:  s = (x == y) ? 1 : 0;
      8:  s = (x < y) ? 1 : 0;
      9:  s = (y >= W) ? 0 : ((x << y) & msk);
      10: s = (y >= W) ? 0 : (x >> y);
      11: s = (y >= W) ? ((sx < 0) ? msk : 0) : (longint'(sx >>> y) & msk);
      12: begin u = x * y; s = u & msk; co = ((u >> W) != 0); end
      default: s = 0;
    endcase
  endfunction

  // Model: result appears one cycle after acceptance, or W+1 cycles for MUL.
  always @(posedge clk) begin
    longint unsigned s;
    bit c, ov, rdy;
    rdy   = !m_busy && (!m_hold || out_ready);
    m_acc = in_valid && rdy && !rst;
    if (rst) begin
      m_busy = 0; m_hold = 0; m_left = 0;
      m_s = 0; m_c = 0; m_z = 0; m_ov = 0;
    end else if (m_busy) begin
      m_left--;
      if (m_left == 0) begin
        m_busy = 0; m_hold = 1;
        m_s = p_s; m_c = p_c; m_z = p_z; m_ov = 0;
      end
    end else if (m_acc) begin
      ref_op(int'(op), longint'(in_x), longint'(in_y), in_c, s, c, ov);
      if (op == 4'd12) begin
        m_busy = 1; m_hold = 0; m_left = W;
        p_s = s; p_c = c; p_z = (s == 0);
      end else begin
        m_hold = 1; m_s = s; m_c = c; m_ov = ov; m_z = (s == 0);
      end
    end else if (m_hold && out_ready) begin
      m_hold = 0;
    end
  end

  always @(negedge clk) begin
    if (chk_en) begin
      chk("in_ready", longint'(in_ready), longint'(!m_busy && (!m_hold || out_ready)));
      chk("out_valid", longint'(out_valid), longint'(m_hold));
      if (m_hold) begin
        chk("out_s", longint'(out_s), m_s);
        chk("out_c", longint'(out_c), longint'(m_c));
        chk("zero", longint'(zero), longint'(m_z));
        chk("overflow", longint'(overflow), longint'(m_ov));
      end
    end
  end

  // Drive a request and return once it has been accepted (n = edges waited).
  task automatic issue(input logic [3:0] o, input logic [W-1:0] x, input logic [W-1:0] y,
                       input logic c, output int n);
    in_valid = 1; op = o; in_x = x; in_y = y; in_c = c;
    n = 0;
    do begin
      @(posedge clk); #1;
      n++;
    end while (!m_acc && n < 50);
    if (!m_acc) chk("accept_timeout", 0, 1);
    in_valid = 0;
  endtask

  initial begin
    int n;
    rst = 1; in_valid = 0; in_c = 0; out_ready = 1; op = 0; in_x = 0; in_y = 0;
    repeat (2) @(posedge clk);
    #1 rst = 0;
    chk_en = 1;

    @(negedge clk);
    chk("rst in_ready", longint'(in_ready), 1);
    chk("rst out_valid", longint'(out_valid), 0);
    chk("rst out_s", longint'(out_s), 0);

    issue(4'd0, 8'h7F, 8'h01, 1'b0, n);
    @(negedge clk);
    chk("add valid", longint'(out_valid), 1);
    chk("add s", longint'(out_s), 64'h80);
    chk("add c", longint'(out_c), 0);
    chk("add ov", longint'(overflow), 1);
    chk("add z", longint'(zero), 0);

    issue(4'd1, 8'h05, 8'h05, 1'b0, n);
    @(negedge clk);
    chk("sub s", longint'(out_s), 0);
    chk("sub z", longint'(zero), 1);
    chk("sub c", longint'(out_c), 1);
    chk("sub ov", longint'(overflow), 0);

    issue(4'd6, 8'hFF, 8'h01, 1'b0, n);
    @(negedge clk) chk("slt s", longint'(out_s), 1);
    issue(4'd8, 8'hFF, 8'h01, 1'b0, n);
    @(negedge clk) chk("sltu s", longint'(out_s), 0);
    issue(4'd11, 8'h80, 8'h0A, 1'b0, n);
    @(negedge clk) chk("sar s", longint'(out_s), 64'hFF);
    issue(4'd9, 8'h81, 8'h01, 1'b0, n);
    @(negedge clk) chk("shl s", longint'(out_s), 64'h02);
    issue(4'd14, 8'h12, 8'h34, 1'b1, n);
    @(negedge clk);
    chk("op14 s", longint'(out_s), 0);
    chk("op14 z", longint'(zero), 1);

    issue(4'd12, 8'h10, 8'h11, 1'b0, n);
    for (int i = 1; i <= 8; i++) begin
      @(negedge clk);
      chk("mul busy in_ready", longint'(in_ready), 0);
    end
    @(negedge clk);
    chk("mul valid", longint'(out_valid), 1);
    chk("mul s", longint'(out_s), 64'h10);
    chk("mul c", longint'(out_c), 1);

    issue(4'd5, 8'hA5, 8'h0F, 1'b0, n);
    out_ready = 0;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      chk("bp valid", longint'(out_valid), 1);
      chk("bp s", longint'(out_s), 64'hAA);
      chk("bp in_ready", longint'(in_ready), 0);
    end
    out_ready = 1;
    issue(4'd0, 8'h01, 8'h02, 1'b0, n);
    chk("b2b accept edges", longint'(n), 1);
    @(negedge clk);
    chk("b2b valid", longint'(out_valid), 1);
    chk("b2b s", longint'(out_s), 64'h03);

    issue(4'd12, 8'h33, 8'h07, 1'b0, n);
    repeat (3) @(posedge clk);
    #1 rst = 1;
    @(posedge clk);
    #1 rst = 0;
    @(negedge clk);
    chk("abort valid", longint'(out_valid), 0);
    chk("abort in_ready", longint'(in_ready), 1);
    chk("abort s", longint'(out_s), 0);
    for (int i = 0; i < 12; i++) begin
      @(negedge clk);
      chk("abort no stale", longint'(out_valid), 0);
    end

    for (int i = 0; i < 3000; i++) begin
      @(posedge clk); #1;
      rst       = ($urandom_range(0, 149) == 0);
      in_valid  = ($urandom_range(0, 3) != 0);
      out_ready = ($urandom_range(0, 3) != 0);
      op        = 4'($urandom_range(0, 15));
      in_c      = 1'($urandom_range(0, 1));
      in_x      = W'($urandom);
      in_y      = ($urandom_range(0, 1) != 0) ? W'($urandom_range(0, 10)) : W'($urandom);
    end
    @(posedge clk); #1;
    rst = 0; in_valid = 0;
    repeat (3) @(negedge clk);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule

// File: doc/alu_seq.md
ALU_SEQ -- requirements
Module: alu_seq

Interface
REQ-001 SHALL have parameter WIDTH, default 8, which sets the operand and result width; legal values are 4 to 32.
REQ-002 SHALL have port clk, input, 1 bit: the single clock; all state updates on its rising edge.
REQ-003 SHALL have port rst, input, 1 bit: reset, synchronous and active-high.
REQ-004 SHALL have port in_valid, input, 1 bit: the operation request is valid.
REQ-005 SHALL have port in_ready, output, 1 bit: the block can accept a request this cycle.
REQ-006 SHALL have port op, input, 4 bits: operation select.
REQ-007 SHALL have port in_c, input, 1 bit: carry-in, used by ADD only.
REQ-008 SHALL have ports in_x and in_y, input, WIDTH bits each: the operands.
REQ-009 SHALL have port out_valid, output, 1 bit: the result is valid.
REQ-010 SHALL have port out_ready, input, 1 bit: the consumer accepts the result.
REQ-011 SHALL have port out_s, output, WIDTH bits: the result.
REQ-012 SHALL have ports out_c, zero and overflow, output, 1 bit each: the result flags, all registered.

Function
REQ-013 SHALL implement three states:
- IDLE: no result held.
- BUSY: multiply in progress.
- HOLD: result presented on the outputs.
REQ-014 SHALL drive in_ready = (state==IDLE) | (state==HOLD & out_ready).
REQ-015 SHALL drive out_valid = (state==HOLD).
REQ-016 SHALL accept a request in any cycle where in_valid & in_ready, capturing op, in_c, in_x and in_y.
REQ-017 SHALL, for a single-cycle op accepted in cycle t, enter HOLD and present the registered result in cycle t+1.
REQ-018 SHALL support these op codes and results:
- 0 ADD: x+y+in_c.
- 1 SUB: x-y.
- 2 NOT: ~x.
- 3 AND: x&y.
- 4 OR: x|y.
- 5 XOR: x^y.
- 6 SLT: signed x<y, zero-extended to WIDTH.
- 7 EQ: x==y, zero-extended.
- 8 SLTU: unsigned x<y, zero-extended.
- 9 SHL: x<<y.
- 10 SHR: logical x>>y.
- 11 SAR: arithmetic x>>>y.
- 12 MUL: low WIDTH bits of unsigned x*y.
- 13-15: result 0, all flags 0.
REQ-019 SHALL compute out_c as follows:
- ADD: carry out of bit WIDTH-1.
- SUB: carry out of x+~y+1, so 1 means no borrow.
- MUL: 1 if any product bit at or above WIDTH is nonzero.
- All other ops: 0.
REQ-020 SHALL compute overflow as the two's-complement overflow for ADD and SUB, and 0 for all other ops.
REQ-021 SHALL set zero = (out_s==0) for every op, including 13-15.
REQ-022 SHALL compare the full unsigned in_y as the shift amount; an amount >= WIDTH gives 0 for SHL and SHR, and all copies of x[WIDTH-1] for SAR.
REQ-023 SHALL execute MUL as an iterative shift-add with a 2*WIDTH accumulator, one multiplier bit per cycle.
REQ-024 SHALL, for MUL accepted in cycle t, spend exactly WIDTH cycles in BUSY and enter HOLD in cycle t+WIDTH+1.
REQ-025 SHALL hold in_ready low during BUSY; in_valid is ignored there.
REQ-026 SHALL keep out_s, out_c, zero and overflow stable while in HOLD with out_ready low.
REQ-027 SHALL, when in HOLD with out_ready high and in_valid low, return to IDLE next cycle.
REQ-028 SHALL, when in HOLD with out_ready & in_valid, retire the current result and accept the new request in the same cycle; the next state is HOLD (new result) or BUSY (MUL).
REQ-029 SHALL make the result a function of the captured operands only; input changes after acceptance have no effect.

Reset
REQ-030 SHALL, with rst high at a rising edge, go to IDLE and clear out_s, out_c, zero, overflow and the accumulator to 0.
REQ-031 SHALL have out_valid=0 and in_ready=1 in the cycle after reset.
REQ-032 SHALL, on rst during BUSY or HOLD, abort the operation and not present the result.
REQ-033 SHALL give rst priority over a simultaneous in_valid; that request is not accepted.

Verification (WIDTH=8)
REQ-034 SHALL cover ADD: x=0x7F, y=0x01, in_c=0 -> next cycle out_s=0x80, out_c=0, overflow=1, zero=0.
REQ-035 SHALL cover SUB: x=0x05, y=0x05 -> out_s=0x00, zero=1, out_c=1, overflow=0; then SLT x=0xFF, y=0x01 -> out_s=0x01, and SLTU with the same operands -> out_s=0x00.
REQ-036 SHALL cover MUL: x=0x10, y=0x11 accepted at cycle t -> in_ready=0 for cycles t+1..t+8; out_valid=1 at t+9 with out_s=0x10, out_c=1.
REQ-037 SHALL cover backpressure: out_ready=0 for 5 cycles in HOLD -> outputs unchanged and in_ready=0; then out_ready=1 together with in_valid -> back-to-back acceptance with no idle cycle.
REQ-038 SHALL cover reset mid-MUL: rst asserted for 1 cycle at BUSY cycle 4 -> next cycle out_valid=0, in_ready=1, out_s=0, and no stale result is ever presented.
REQ-039 SHALL cover shifts: SAR x=0x80, y=0x0A -> 0xFF; SHL x=0x81, y=0x01 -> 0x02; op=14 -> out_s=0, zero=1.
